// File: rtl/regfile_seq_ctrl.sv
// rtl/regfile_seq_ctrl.sv - sequencer for an 8x4 register file: init, reverse and bubble sort.
// All outputs come straight from registered state, so inputs never reach them combinationally.
module regfile_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic        abort,
  input  logic [31:0] r_flat,
  output logic        init,
  output logic        swap,
  output logic [2:0]  x,
  output logic [2:0]  y,
  output logic        busy,
  output logic        done,
  output logic [4:0]  swap_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_REV  = 3'd2;
  localparam logic [2:0] S_CMP  = 3'd3;
  localparam logic [2:0] S_SWP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0] state_q, state_d;
  logic [2:0] j_q, j_d;
  logic [2:0] limit_q, limit_d;
  logic       pass_swapped_q, pass_swapped_d;
  logic       desc_q, desc_d;
  logic [2:0] x_q, x_d;
  logic [2:0] y_q, y_d;
  logic [4:0] cnt_q, cnt_d;

  logic [2:0] j_nxt;
  logic [3:0] r_a, r_b;
  logic       out_of_order;
  logic       end_pass;

  assign j_nxt        = j_q + 3'd1;
  assign r_a          = r_flat[{j_q, 2'b00} +: 4];
  assign r_b          = r_flat[{j_nxt, 2'b00} +: 4];
  assign out_of_order = desc_q ? (r_a < r_b) : (r_a > r_b);
  assign end_pass     = (j_nxt == limit_q);

  always_comb begin
    state_d        = state_q;
    j_d            = j_q;
    limit_d        = limit_q;
    pass_swapped_d = pass_swapped_q;
    desc_d         = desc_q;
    x_d            = x_q;
    y_d            = y_q;
    cnt_d          = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d          = 5'd0;
          j_d            = 3'd0;
          limit_d        = 3'd7;
          pass_swapped_d = 1'b0;
          desc_d         = mode[0];
          if (mode == 2'b00) begin
            state_d = S_INIT;
          end else if (mode == 2'b01) begin
            state_d = S_REV;
            x_d     = 3'd0;
            y_d     = 3'd7;
          end else begin
            state_d = S_CMP;
          end
        end
      end
      S_INIT: state_d = S_DONE;
      S_REV: begin
        cnt_d = cnt_q + 5'd1;
        if (j_q == 3'd3) begin
          state_d = S_DONE;
        end else begin
          j_d = j_nxt;
          x_d = x_q + 3'd1;
          y_d = y_q - 3'd1;
        end
      end
      S_CMP: begin
        if (out_of_order) begin
          state_d = S_SWP;
          x_d     = j_q;
          y_d     = j_nxt;
        end else if (end_pass) begin
          if (!pass_swapped_q || limit_q == 3'd1) begin
            state_d = S_DONE;
          end else begin
            limit_d        = limit_q - 3'd1;
            j_d            = 3'd0;
            pass_swapped_d = 1'b0;
          end
        end else begin
          j_d = j_nxt;
        end
      end
      S_SWP: begin
        cnt_d          = cnt_q + 5'd1;
        pass_swapped_d = 1'b1;
        state_d        = S_CMP;
        // The swap itself marks this pass dirty, so only limit decides termination here.
        if (end_pass) begin
          if (limit_q == 3'd1) begin
            state_d = S_DONE;
          end else begin
            limit_d        = limit_q - 3'd1;
            j_d            = 3'd0;
            pass_swapped_d = 1'b0;
          end
        end else begin
          j_d = j_nxt;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE && state_q != S_DONE) begin
      state_d = S_IDLE;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      j_q            <= 3'd0;
      limit_q        <= 3'd0;
      pass_swapped_q <= 1'b0;
      desc_q         <= 1'b0;
      x_q            <= 3'd0;
      y_q            <= 3'd0;
      cnt_q          <= 5'd0;
    end else begin
      state_q        <= state_d;
      j_q            <= j_d;
      limit_q        <= limit_d;
      pass_swapped_q <= pass_swapped_d;
      desc_q         <= desc_d;
      x_q            <= x_d;
      y_q            <= y_d;
      cnt_q          <= cnt_d;
    end
  end

  assign init       = (state_q == S_INIT);
  assign swap       = (state_q == S_REV) || (state_q == S_SWP);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign x          = x_q;
  assign y          = y_q;
  assign swap_count = cnt_q;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// tb/tb_regfile_seq_ctrl.sv - scoreboard bench for regfile_seq_ctrl with a behavioural register file.
module tb_regfile_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        abort = 1'b0;
  logic [31:0] r_flat;
  logic        init, swap, busy, done;
  logic [2:0]  x, y;
  logic [4:0]  swap_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;

  typedef struct {
    logic [4:0]  sc;
    logic [31:0] r;
    int          lat;
  } done_t;

  done_t      done_q[$];
  logic [5:0] pair_q[$];

  logic [3:0] rm [8];

  localparam logic [31:0] R_UP   = 32'h7654_3210;
  localparam logic [31:0] R_DOWN = 32'h0123_4567;

  regfile_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
    .r_flat(r_flat), .init(init), .swap(swap), .x(x), .y(y),
    .busy(busy), .done(done), .swap_count(swap_count)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 8; i++) rm[i] = 4'hF;
  end

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 8; i++) rm[i] <= 4'(i);
    end else if (swap) begin
      rm[x] <= rm[y];
      rm[y] <= rm[x];
    end
  end

  always_comb begin
    r_flat = 32'd0;
    for (int i = 0; i < 8; i++) r_flat[i*4 +: 4] = rm[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every swap, init and done the DUT presents against the queues.
  always @(negedge clk) begin
    done_t d;
    logic [5:0] p;
    cyc++;
    if (rst_n) begin
      if (init && swap) chk("init_swap_exclusive", 32'd1, 32'd0);
      if (init) chk("init_latency", 32'(cyc - start_cyc), 32'd1);
      if (swap) begin
        if (pair_q.size() == 0) begin
          chk("unexpected_swap", {26'd0, x, y}, 32'h3F);
        end else begin
          p = pair_q.pop_front();
          chk("swap_pair", {26'd0, x, y}, {26'd0, p});
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          d = done_q.pop_front();
          chk("done_swap_count", {27'd0, swap_count}, {27'd0, d.sc});
          chk("done_regfile", r_flat, d.r);
          chk("done_latency", 32'(cyc - start_cyc), 32'(d.lat));
          chk("done_busy", {31'd0, busy}, 32'd1);
        end
      end
      if (start && !busy) start_cyc = cyc;
    end
  end

  task automatic pulse_start(input logic [1:0] m);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic run_cmd(input string name, input logic [1:0] m, input logic [4:0] sc,
                         input logic [31:0] r, input int lat);
    done_t d;
    d.sc  = sc;
    d.r   = r;
    d.lat = lat;
    done_q.push_back(d);
    pulse_start(m);
    wait_idle(name);
    @(posedge clk); #1;
  endtask

  task automatic push_sort_pairs();
    for (int l = 7; l >= 1; l--)
      for (int j = 0; j < l; j++) pair_q.push_back({3'(j), 3'(j + 1)});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_outputs", {20'd0, init, swap, done, x, y, swap_count}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {31'd0, busy}, 32'd0);

    run_cmd("init", 2'b00, 5'd0, R_UP, 2);

    // Reset in the second reverse swap cycle: only the first swap happens.
    pair_q.push_back({3'd0, 3'd7});
    pulse_start(2'b01);
    @(posedge clk); #1;
    chk("rev_second_pair_x", {29'd0, x}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    chk("async_reset_outputs", {20'd0, init, swap, done, x, y, swap_count}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_release", {31'd0, busy}, 32'd0);
    chk("regfile_not_restored", r_flat, 32'h0654_3217);

    run_cmd("init2", 2'b00, 5'd0, R_UP, 2);
    for (int i = 0; i < 4; i++) pair_q.push_back({3'(i), 3'(7 - i)});
    run_cmd("reverse", 2'b01, 5'd4, R_DOWN, 5);
    chk("count_holds_after_done", {27'd0, swap_count}, 32'd4);

    push_sort_pairs();
    run_cmd("sort_asc_rev", 2'b10, 5'd28, R_UP, 57);
    run_cmd("sort_asc_sorted", 2'b10, 5'd0, R_UP, 8);
    push_sort_pairs();
    run_cmd("sort_desc", 2'b11, 5'd28, R_DOWN, 57);

    // Abort after the third swap of an ascending sort; a start during the sort is ignored.
    for (int i = 0; i < 3; i++) pair_q.push_back({3'(i), 3'(i + 1)});
    pulse_start(2'b10);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if (swap_count == 5'd3 && !swap) begin
          hit = 1'b1;
          break;
        end
        @(posedge clk); #1;
      end
      if (!hit) chk("abort_wait_timeout", 32'd1, 32'd0);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_count", {27'd0, swap_count}, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_still_idle", {31'd0, busy}, 32'd0);
    chk("abort_count_held", {27'd0, swap_count}, 32'd3);
    chk("abort_regfile", r_flat, 32'h0123_7456);

    chk("pair_queue_drained", 32'(pair_q.size()), 32'd0);
    chk("done_queue_drained", 32'(done_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_seq_ctrl.md
REGFILE_SEQ_CTRL -- requirements
Module: regfile_seq_ctrl

Interface
REQ-001 The block SHALL have the ports clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1, reset: asynchronous, active-low.
REQ-003 The block SHALL have the port start, input, 1, command request; sampled only in IDLE.
REQ-004 The block SHALL have the port mode, input, 2, command: 00 init, 01 reverse, 10 sort ascending, 11 sort descending.
REQ-005 The block SHALL have the port abort, input, 1, synchronous cancel of the current command.
REQ-006 The block SHALL have the port r_flat, input, 32, register file contents; r[i] = r_flat[4i+3:4i], i = 0..7.
REQ-007 The block SHALL have the ports init, swap, x[2:0] and y[2:0], all outputs, which drive the register file of the same names.
REQ-008 The block SHALL have the port busy, output, 1, high in every state except IDLE.
REQ-009 The block SHALL have the port done, output, 1, one-cycle completion pulse.
REQ-010 The block SHALL have the port swap_count, output, 5, number of swap cycles issued by the current or last command.

Function
REQ-011 All outputs SHALL be registered or decoded only from registered state (Moore); no combinational path from inputs to outputs.
REQ-012 The register file model SHALL behave as follows on each rising clk edge: init=1 loads r[i]=i; else swap=1 exchanges r[x] and r[y]; init has priority.
REQ-013 The FSM SHALL have the states IDLE, INIT, REV, CMP, SWP and DONE.
REQ-014 In IDLE with start=1, the FSM SHALL clear swap_count and go to INIT (00), REV (01) or CMP (1x) with j=0, limit=7 and pass_swapped=0.
REQ-015 INIT SHALL last one cycle with init=1 and then go to DONE.
REQ-016 REV SHALL last four consecutive cycles with swap=1 and (x,y) = (0,7), (1,6), (2,5), (3,4) in that order, incrementing swap_count each cycle, and then go to DONE.
REQ-017 In CMP, the block SHALL compare r[j] and r[j+1], unsigned 4-bit; an out-of-order pair (r[j] > r[j+1] ascending, r[j] < r[j+1] descending) SHALL go to SWP, and an equal or in-order pair SHALL advance j.
REQ-018 SWP SHALL last exactly one cycle with swap=1, x=j and y=j+1; it SHALL set pass_swapped, increment swap_count, advance j and return to CMP.
REQ-019 When j reaches limit, end of pass: if pass_swapped=0 or limit=1, the FSM SHALL go to DONE; otherwise limit SHALL decrement, j=0, pass_swapped=0 and the FSM SHALL stay in CMP.
REQ-020 The CMP following a SWP SHALL observe the updated r_flat, because the register file updates at the end of the SWP cycle.
REQ-021 DONE SHALL last one cycle with done=1 and busy=1, then go to IDLE unconditionally.
REQ-022 In any non-IDLE state except DONE, abort=1 SHALL return the FSM to IDLE on the next edge with no done pulse; swap_count SHALL hold its value.
REQ-023 start while busy SHALL be ignored; it SHALL NOT be queued.
REQ-024 init and swap SHALL never be high in the same cycle; x and y SHALL hold their last values when swap=0.
REQ-025 swap_count SHALL hold its value after DONE until the next accepted start; the maximum count is 28, so it never wraps.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force state=IDLE and init=swap=busy=done=0, x=y=0, swap_count=0, and clear j, limit and pass_swapped.
REQ-027 Reset asserted mid-command SHALL abandon the command with no done pulse; the register file contents are not restored.

Verification
REQ-028 Reset during REV (second swap cycle) -> all outputs 0 asynchronously, before the next clk edge; IDLE after release.
REQ-029 start with mode=00 at edge E -> init=1 in cycle E+1, done=1 in cycle E+2, r = 0..7, swap_count=0.
REQ-030 After init, start with mode=01 -> four swap cycles with pairs in order, r = 7,6,5,4,3,2,1,0, swap_count=4, done one cycle after the last swap.
REQ-031 From r = 7..0, start with mode=10 -> r = 0..7, swap_count=28; from r = 0..7, mode=11 -> r = 7..0, swap_count=28.
REQ-032 From r = 0..7, start with mode=10 -> exactly 7 CMP cycles with no swap, done in the next cycle, swap_count=0.
REQ-033 Mode=10 with abort asserted after the third swap -> IDLE with no done and swap_count=3; start pulsed during the sort has no effect.
